// File: rtl/xbar_arbiter.sv
//------------------------------------------------------------------------------
// Module  : xbar_arbiter
// Brief   : 5x5 crossbar output arbiter, per-output round-robin, registered
//           route selects with one-cycle issue latency.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module xbar_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_n_i,
  input  logic       valid_s_i,
  input  logic       valid_e_i,
  input  logic       valid_w_i,
  input  logic       valid_l_i,
  input  logic [2:0] dest_n_i,
  input  logic [2:0] dest_s_i,
  input  logic [2:0] dest_e_i,
  input  logic [2:0] dest_w_i,
  input  logic [2:0] dest_l_i,
  input  logic       ready_n_i,
  input  logic       ready_s_i,
  input  logic       ready_e_i,
  input  logic       ready_w_i,
  input  logic       ready_l_i,
  output logic [2:0] address_route_n_o,
  output logic [2:0] address_route_s_o,
  output logic [2:0] address_route_e_o,
  output logic [2:0] address_route_w_o,
  output logic [2:0] address_route_l_o
);

  localparam logic [2:0] c_NO_GRANT = 3'b000;
  localparam logic [2:0] c_CODE_L   = 3'b101;

  // Port index 0..4 = N,S,E,W,L; port code = index + 1.
  logic [4:0]      w_valid;
  logic [4:0]      w_ready;
  logic [4:0][2:0] w_dest;
  logic [4:0][2:0] r_route;
  logic [4:0][2:0] r_ptr;
  logic [4:0][2:0] w_win;
  logic [5:1]      w_popped;
  logic [4:0][5:1] w_req;

  assign w_valid = {valid_l_i, valid_w_i, valid_e_i, valid_s_i, valid_n_i};
  assign w_ready = {ready_l_i, ready_w_i, ready_e_i, ready_s_i, ready_n_i};
  assign w_dest  = {dest_l_i, dest_w_i, dest_e_i, dest_s_i, dest_n_i};

  assign address_route_n_o = r_route[0];
  assign address_route_s_o = r_route[1];
  assign address_route_e_o = r_route[2];
  assign address_route_w_o = r_route[3];
  assign address_route_l_o = r_route[4];

  // Code of the k-th input after pointer p in cyclic order N,S,E,W,L.
  function automatic logic [2:0] f_rr_code(input logic [2:0] p, input int k);
    int t;
    t = (int'(p) + k - 1) % 5 + 1;
    return 3'(t);
  endfunction

  // Inputs currently shown on any route are being popped and must not win again.
  always_comb begin
    w_popped = '0;
    for (int y = 0; y < 5; y++) begin
      if (r_route[y] != c_NO_GRANT && r_route[y] <= c_CODE_L) begin
        w_popped[r_route[y]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_req = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        w_req[y][x+1] = w_valid[x] && (w_dest[x] == 3'(y + 1)) && !w_popped[x+1];
      end
    end
  end

  // Scanning from the far end and overwriting leaves the nearest requester.
  always_comb begin
    w_win = '0;
    for (int y = 0; y < 5; y++) begin
      if (w_ready[y]) begin
        for (int k = 5; k >= 1; k--) begin
          if (w_req[y][f_rr_code(r_ptr[y], k)]) begin
            w_win[y] = f_rr_code(r_ptr[y], k);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int y = 0; y < 5; y++) begin
        r_route[y] <= c_NO_GRANT;
        r_ptr[y]   <= c_CODE_L;
      end
    end else begin
      for (int y = 0; y < 5; y++) begin
        r_route[y] <= w_win[y];
        if (w_win[y] != c_NO_GRANT) begin
          r_ptr[y] <= w_win[y];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xbar_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_xbar_arbiter
// Brief   : Self-checking bench for xbar_arbiter: vector table, directed
//           multi-cycle sequences and randomized traffic against a model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_xbar_arbiter;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4:0]      vld = '0;
  logic [4:0]      rdy = '0;
  logic [4:0][2:0] dst = '0;
  logic [4:0][2:0] rt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: current routes and per-output priority order (last granted at the back).
  int m_route[5];
  int m_order[5][5];

  typedef struct packed {
    logic [4:0]      valid;
    logic [4:0][2:0] dest;
    logic [4:0]      ready;
    logic [4:0][2:0] exp;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  xbar_arbiter dut (
    .clk(clk), .rst(rst),
    .valid_n_i(vld[0]), .valid_s_i(vld[1]), .valid_e_i(vld[2]),
    .valid_w_i(vld[3]), .valid_l_i(vld[4]),
    .dest_n_i(dst[0]), .dest_s_i(dst[1]), .dest_e_i(dst[2]),
    .dest_w_i(dst[3]), .dest_l_i(dst[4]),
    .ready_n_i(rdy[0]), .ready_s_i(rdy[1]), .ready_e_i(rdy[2]),
    .ready_w_i(rdy[3]), .ready_l_i(rdy[4]),
    .address_route_n_o(rt[0]), .address_route_s_o(rt[1]),
    .address_route_e_o(rt[2]), .address_route_w_o(rt[3]),
    .address_route_l_o(rt[4])
  );

  function automatic logic [14:0] mk(input logic [2:0] n, s, e, w, l);
    return {l, w, e, s, n};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got L,W,E,S,N=%o required %o", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic model_reset;
    for (int y = 0; y < 5; y++) begin
      m_route[y] = 0;
      for (int i = 0; i < 5; i++) m_order[y][i] = i + 1;
    end
  endtask

  task automatic model_clock;
    int  nr[5];
    bit  popped[6];
    int  tmp;
    for (int c = 0; c < 6; c++) popped[c] = 1'b0;
    for (int y = 0; y < 5; y++) popped[m_route[y]] = 1'b1;
    for (int y = 0; y < 5; y++) begin
      nr[y] = 0;
      if (rdy[y]) begin
        for (int i = 0; i < 5; i++) begin
          int c;
          c = m_order[y][i];
          if (nr[y] == 0 && vld[c-1] && int'(dst[c-1]) == y + 1 && !popped[c]) nr[y] = c;
        end
      end
      if (nr[y] != 0) begin
        while (m_order[y][4] != nr[y]) begin
          tmp = m_order[y][0];
          for (int i = 0; i < 4; i++) m_order[y][i] = m_order[y][i+1];
          m_order[y][4] = tmp;
        end
      end
    end
    for (int y = 0; y < 5; y++) m_route[y] = nr[y];
  endtask

  function automatic logic [14:0] model_out;
    logic [14:0] v;
    for (int y = 0; y < 5; y++) v[3*y +: 3] = 3'(m_route[y]);
    return v;
  endfunction

  initial begin
    // Single-cycle vectors, each applied right after reset (N has first priority).
    vecs[0] = '{5'b11111, {3'b100, 3'b011, 3'b101, 3'b001, 3'b010}, 5'b11111,
                mk(3'b010, 3'b001, 3'b100, 3'b101, 3'b011)};
    vecs[1] = '{5'b00100, {3'b000, 3'b000, 3'b111, 3'b000, 3'b000}, 5'b11111, '0};
    vecs[2] = '{5'b01011, {3'b000, 3'b011, 3'b000, 3'b011, 3'b011}, 5'b00100,
                mk(3'b000, 3'b000, 3'b001, 3'b000, 3'b000)};
    vecs[3] = '{5'b10010, {3'b001, 3'b000, 3'b000, 3'b001, 3'b000}, 5'b11111,
                mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000)};
    vecs[4] = '{5'b10000, {3'b100, 3'b000, 3'b000, 3'b000, 3'b000}, 5'b10111, '0};
    vecs[5] = '{5'b01100, {3'b000, 3'b011, 3'b011, 3'b000, 3'b000}, 5'b11111,
                mk(3'b000, 3'b000, 3'b011, 3'b000, 3'b000)};
    vecs[6] = '{5'b00011, {3'b000, 3'b000, 3'b000, 3'b110, 3'b000}, 5'b11111, '0};
    vecs[7] = '{5'b00000, {3'b001, 3'b010, 3'b011, 3'b100, 3'b101}, 5'b11111, '0};

    // Reset holds outputs low even with a live request.
    rst = 1'b1;
    vld = 5'b00001; dst[0] = 3'b011; rdy = 5'b11111;
    step();
    check("reset_hold_1", rt, '0);
    step();
    check("reset_hold_2", rt, '0);
    rst = 1'b0;
    step();
    check("reset_first_grant", rt, mk(3'b000, 3'b000, 3'b001, 3'b000, 3'b000));

    for (int i = 0; i < 8; i++) begin
      do_reset();
      vld = vecs[i].valid; dst = vecs[i].dest; rdy = vecs[i].ready;
      step();
      check($sformatf("vec_%0d", i), rt, vecs[i].exp);
    end

    // Round robin among N,S,W on E with the popped input masked each cycle.
    vld = '0; dst = '0; rdy = '0;
    do_reset();
    vld = 5'b01011; dst = {3'b000, 3'b011, 3'b000, 3'b011, 3'b011}; rdy = 5'b00100;
    begin
      logic [2:0] seq[6];
      seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 6; i++) begin
        step();
        check($sformatf("rr_%0d", i), rt, mk(3'b000, 3'b000, seq[i], 3'b000, 3'b000));
      end
    end

    // Back-pressure on W, then release.
    vld = '0; dst = '0; rdy = '0;
    do_reset();
    vld = 5'b10000; dst[4] = 3'b100; rdy = 5'b10111;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("bp_stall_%0d", i), rt, '0);
    end
    rdy = 5'b11111;
    step();
    check("bp_release", rt, mk(3'b000, 3'b000, 3'b000, 3'b101, 3'b000));

    // Mid-cycle reset clears asynchronously; arbitration restarts with N first.
    vld = '0; dst = '0;
    do_reset();
    vld = 5'b00010; dst[1] = 3'b001; rdy = 5'b11111;
    step();
    check("mid_pre", rt, mk(3'b010, 3'b000, 3'b000, 3'b000, 3'b000));
    #3 rst = 1'b1;
    #1;
    check("mid_async_clear", rt, '0);
    step();
    rst = 1'b0;
    vld = 5'b00011; dst[0] = 3'b001; dst[1] = 3'b001;
    step();
    check("mid_restart", rt, mk(3'b001, 3'b000, 3'b000, 3'b000, 3'b000));

    // Randomized traffic against the model.
    vld = '0; dst = '0; rdy = '0;
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int x = 0; x < 5; x++) begin
        vld[x] = ($urandom_range(0, 3) != 0);
        dst[x] = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                             : 3'($urandom_range(1, 3));
        rdy[x] = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk);
      model_clock();
      #1;
      check($sformatf("rand_%0d", cyc), rt, model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xbar_arbiter.md
XBAR_ARBITER -- requirements
Module: xbar_arbiter

Interface
- REQ-001: The block SHALL have no parameters; port count (5: N,S,E,W,L) and route-code width (3) SHALL be fixed.
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: rst  input  1  reset, asynchronous, active-high.
- REQ-004: valid_{n,s,e,w,l}_i  input  1 each  input queue X holds a head flit.
- REQ-005: dest_{n,s,e,w,l}_i  input  3 each  output port requested by the head flit of queue X; codes 001=N, 010=S, 011=E, 100=W, 101=L.
- REQ-006: ready_{n,s,e,w,l}_i  input  1 each  output port Y can accept a flit next cycle.
- REQ-007: address_route_{n,s,e,w,l}_o  output  3 each  registered select for output Y's crossbar mux: input queue granted, same code set as REQ-005; 000 means no grant.

Function
- REQ-008: Input X SHALL request output Y in a cycle iff valid_X_i=1, dest_X_i equals Y's code, and X is not masked (REQ-011).
- REQ-009: dest codes 000, 110 and 111 SHALL be treated as no request, with no state change for that input.
- REQ-010: Output Y SHALL be eligible to grant only when ready_Y_i=1 in the sampling cycle; otherwise address_route_Y_o SHALL load 000 and ptr_Y SHALL hold.
- REQ-011: An input whose code appears on any address_route_*_o in the current cycle is being popped this cycle and SHALL be masked from arbitration in that cycle (no duplicate grant of one flit).
- REQ-012: Each output SHALL keep a 3-bit round-robin pointer ptr_Y holding the code of its last granted input.
- REQ-013: Search order SHALL be cyclic N,S,E,W,L, starting at the input after ptr_Y; the first requesting input wins.
- REQ-014: On a grant, address_route_Y_o SHALL load the winner's code at the next rising edge, and ptr_Y SHALL load the same code on that edge.
- REQ-015: Latency: a request sampled in cycle t SHALL appear on address_route_Y_o in cycle t+1; 1-cycle issue, no combinational path from inputs to outputs.
- REQ-016: Each input SHALL be granted by at most one output per cycle (guaranteed by its single dest); each output SHALL grant at most one input.
- REQ-017: With no requesters for Y, address_route_Y_o SHALL load 000 and ptr_Y SHALL hold.
- REQ-018: Wrap-around: with ptr_Y=101 (L) the search SHALL start at N; with ptr_Y=001 it SHALL start at S.
- REQ-019: A continuously requesting input SHALL be granted at most every second cycle (REQ-011 mask); under full load on one output from k inputs, each input SHALL be granted within 2k cycles.
- REQ-020: All five outputs SHALL arbitrate independently and simultaneously in the same cycle.
- REQ-021: A U-turn request (dest equal to the input's own port) SHALL be arbitrated like any other request.

Reset
- REQ-022: While rst=1, all address_route_*_o SHALL be 000 and all ptr_Y SHALL be 101 (so N has first priority after reset).
- REQ-023: Assertion of rst mid-operation SHALL clear outputs asynchronously within the same cycle and drop all pending grants.
- REQ-024: After rst deasserts, the first grant SHALL appear no earlier than one rising edge after a request is sampled.

Verification
- REQ-025: Reset: rst pulse with valid_n_i=1, dest_n_i=011 -> all outputs 000 during reset; after release, address_route_e_o=001 at the edge following the first sampled cycle.
- REQ-026: Round robin: valid N,S,W=1, all dest=011, ready_e_i=1, held steady -> address_route_e_o sequence 001,010,100,001,... with no repeat while REQ-011 masks the popped input.
- REQ-027: Back-pressure: ready_w_i=0, valid_l_i=1, dest_l_i=100 for 4 cycles -> address_route_w_o=000 throughout and ptr_W unchanged; ready_w_i=1 -> 101 on the next cycle.
- REQ-028: Parallel grants: N->S, S->N, E->L, W->E, L->W simultaneously, all ready -> next cycle address_route_s_o=001, n_o=010, l_o=011, e_o=100, w_o=101.
- REQ-029: Illegal dest: valid_e_i=1, dest_e_i=111 -> all outputs stay 000 and pointers unchanged.
- REQ-030: Mid-operation reset: rst asserted between edges while address_route_n_o=010 -> output drops to 000 before the next edge, and the next arbitration starts from N priority.
